// File: rtl/sys_array_pkg.sv
// Shared types and sizing for the systolic array operand feeder.
package sys_array_pkg;

    localparam int ARRAY_N_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;

    // Number of FEED cycles needed to push a fully skewed N x N operand wavefront.
    function automatic int feed_len(input int n);
        return 3 * n - 2;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DONE
    } feed_state_t;

endpackage

// File: rtl/feed_lane.sv
// One edge lane: picks element (t - LANE) of its row/column slice, or 0 outside the skew window.
module feed_lane
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ARRAY_N    = ARRAY_N_DEF,
    parameter int LANE       = 0,
    parameter int TW         = 4
) (
    input  logic [TW-1:0]                 t,
    input  logic [ARRAY_N*DATA_WIDTH-1:0] slice,
    output logic [DATA_WIDTH-1:0]         elem
);

    int k;

    always_comb begin
        elem = '0;
        k    = int'(t) - LANE;
        if (k >= 0 && k < ARRAY_N) begin
            elem = slice[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/sys_array_feeder.sv
// Skewed operand feeder for an N x N systolic array; holds A and B and streams them on the west/north edges.
// Build option: define SYS_FEED_AUTO_CLEAR_EN to insert a one-cycle CLEAR state driving array_clr.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | ready, accepting operand writes and start
// ST_CLEAR | one cycle of array_clr before the wavefront
// ST_FEED  | 3*N-2 cycles of skewed lane data, valid_out high
// ST_DONE  | one-cycle done pulse, array results final
module sys_array_feeder
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ARRAY_N    = ARRAY_N_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic                          wr_sel,
    input  logic [$clog2(ARRAY_N)-1:0]    wr_row,
    input  logic [$clog2(ARRAY_N)-1:0]    wr_col,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          start,
    output logic                          ready,
    output logic                          busy,
    output logic [ARRAY_N*DATA_WIDTH-1:0] west_data,
    output logic [ARRAY_N*DATA_WIDTH-1:0] north_data,
    output logic                          valid_out,
    output logic                          array_clr,
    output logic                          done
);

    localparam int FEED_LEN = feed_len(ARRAY_N);
    localparam int TW       = (FEED_LEN > 1) ? $clog2(FEED_LEN) : 1;

    feed_state_t          state_q, state_nxt;
    logic [TW-1:0]        t_q, t_nxt;

    logic [DATA_WIDTH-1:0] mat_a [ARRAY_N][ARRAY_N];
    logic [DATA_WIDTH-1:0] mat_b [ARRAY_N][ARRAY_N];
    logic [DATA_WIDTH-1:0] a_nxt [ARRAY_N][ARRAY_N];
    logic [DATA_WIDTH-1:0] b_nxt [ARRAY_N][ARRAY_N];

    logic [ARRAY_N*DATA_WIDTH-1:0] a_row [ARRAY_N];
    logic [ARRAY_N*DATA_WIDTH-1:0] b_col [ARRAY_N];
    logic [DATA_WIDTH-1:0]         w_elem [ARRAY_N];
    logic [DATA_WIDTH-1:0]         n_elem [ARRAY_N];

    // Lanes read the post-write matrices so a write coinciding with start is fed.
    always_comb begin
        a_nxt = mat_a;
        b_nxt = mat_b;
        if (state_q == ST_IDLE && wr_en) begin
            if (wr_sel) b_nxt[wr_row][wr_col] = wr_data;
            else        a_nxt[wr_row][wr_col] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mat_a <= '{default: '0};
            mat_b <= '{default: '0};
        end else begin
            mat_a <= a_nxt;
            mat_b <= b_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_nxt;
            t_q     <= t_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        t_nxt     = t_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef SYS_FEED_AUTO_CLEAR_EN
                    state_nxt = ST_CLEAR;
`else
                    state_nxt = ST_FEED;
`endif
                    t_nxt     = '0;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_FEED;
                t_nxt     = '0;
            end
            ST_FEED: begin
                if (t_q == TW'(FEED_LEN - 1)) state_nxt = ST_DONE;
                else                          t_nxt     = t_q + 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        a_row = '{default: '0};
        b_col = '{default: '0};
        for (int i = 0; i < ARRAY_N; i++) begin
            for (int k = 0; k < ARRAY_N; k++) begin
                a_row[i][k*DATA_WIDTH +: DATA_WIDTH] = a_nxt[i][k];
                b_col[i][k*DATA_WIDTH +: DATA_WIDTH] = b_nxt[k][i];
            end
        end
    end

    for (genvar g = 0; g < ARRAY_N; g++) begin : g_lane
        feed_lane #(.DATA_WIDTH(DATA_WIDTH), .ARRAY_N(ARRAY_N), .LANE(g), .TW(TW)) u_west (
            .t     (t_nxt),
            .slice (a_row[g]),
            .elem  (w_elem[g])
        );
        feed_lane #(.DATA_WIDTH(DATA_WIDTH), .ARRAY_N(ARRAY_N), .LANE(g), .TW(TW)) u_north (
            .t     (t_nxt),
            .slice (b_col[g]),
            .elem  (n_elem[g])
        );
    end

    // Lane registers load the value for the cycle being entered, so FEED cycle t sees a stable word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            west_data  <= '0;
            north_data <= '0;
        end else begin
            for (int i = 0; i < ARRAY_N; i++) begin
                west_data[i*DATA_WIDTH +: DATA_WIDTH]  <= (state_nxt == ST_FEED) ? w_elem[i] : '0;
                north_data[i*DATA_WIDTH +: DATA_WIDTH] <= (state_nxt == ST_FEED) ? n_elem[i] : '0;
            end
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign valid_out = (state_q == ST_FEED);
    assign done      = (state_q == ST_DONE);
`ifdef SYS_FEED_AUTO_CLEAR_EN
    assign array_clr = (state_q == ST_CLEAR);
`else
    assign array_clr = 1'b0;
`endif

endmodule

// File: tb/tb_sys_array_feeder.sv
// Randomized bench for sys_array_feeder against a matrix-level reference and a behavioural 4x4 MAC array.
module tb_sys_array_feeder;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int FL = 3 * N - 2;
`ifdef SYS_FEED_AUTO_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en, wr_sel, start;
    logic [1:0]       wr_row, wr_col;
    logic [W-1:0]     wr_data;
    logic             ready, busy, valid_out, array_clr, done;
    logic [N*W-1:0]   west_data, north_data;

    sys_array_feeder #(.DATA_WIDTH(W), .ARRAY_N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .start      (start),
        .ready      (ready),
        .busy       (busy),
        .west_data  (west_data),
        .north_data (north_data),
        .valid_out  (valid_out),
        .array_clr  (array_clr),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference operand matrices.
    logic [W-1:0] ref_a [N][N];
    logic [W-1:0] ref_b [N][N];
    logic [W-1:0] w_hist [FL][N];
    logic [W-1:0] n_hist [FL][N];

    function automatic logic [N*W-1:0] exp_west(input int t);
        logic [N*W-1:0] e = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) e[i*W +: W] = ref_a[i][t-i];
        return e;
    endfunction

    function automatic logic [N*W-1:0] exp_north(input int t);
        logic [N*W-1:0] e = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) e[j*W +: W] = ref_b[t-j][j];
        return e;
    endfunction

    function automatic int prod(input int i, input int j);
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(ref_a[i][k]) * int'(ref_b[k][j]);
        return s;
    endfunction

    // Behavioural systolic array: operands move east/south one PE per cycle.
    logic [W-1:0] ain [N][N], bin [N][N];
    logic [W-1:0] preg_a [N][N], preg_b [N][N];
    int           acc [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ain[i][j] = (j == 0) ? west_data[i*W +: W] : '0;
                bin[i][j] = (i == 0) ? north_data[j*W +: W] : '0;
            end
            for (int j = 1; j < N; j++) ain[i][j] = preg_a[i][j-1];
        end
        for (int i = 1; i < N; i++)
            for (int j = 0; j < N; j++) bin[i][j] = preg_b[i-1][j];
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst || array_clr || (ready && start)) begin
                    acc[i][j]    <= 0;
                    preg_a[i][j] <= '0;
                    preg_b[i][j] <= '0;
                end else begin
                    acc[i][j]    <= acc[i][j] + int'(ain[i][j]) * int'(bin[i][j]);
                    preg_a[i][j] <= ain[i][j];
                    preg_b[i][j] <= bin[i][j];
                end
            end
        end
    end

    int clr_seen = 0, clr_exp = 0, both_seen = 0;
    always @(negedge clk) begin
        if (array_clr) clr_seen++;
        if (ready && busy) both_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_el(input logic sel, input int r, input int c, input logic [W-1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
        tick();
        wr_en = 1'b0;
        if (sel) ref_b[r][c] = d;
        else     ref_a[r][c] = d;
    endtask

    // Issues start (with whatever write the caller set up), then checks every FEED cycle and the array result.
    task automatic run_feed(input bit inject_wr);
        int c;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        c = 1;
        clr_exp += CLR;
        check_val("clr_pulse", array_clr, 1'(CLR));
        while (!valid_out && c < 4) begin
            tick();
            c++;
        end
        check_val("feed_lat", c, CLR + 1);
        for (int t = 0; t < FL; t++) begin
            check_val($sformatf("valid_t%0d", t), valid_out, 1);
            check_val($sformatf("west_t%0d", t), west_data, exp_west(t));
            check_val($sformatf("north_t%0d", t), north_data, exp_north(t));
            for (int i = 0; i < N; i++) begin
                w_hist[t][i] = west_data[i*W +: W];
                n_hist[t][i] = north_data[i*W +: W];
            end
            if (inject_wr && t == 2) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd99;
            end
            tick();
            wr_en = 1'b0;
        end
        c += FL;
        check_val($sformatf("done_at_c%0d", c), done, 1);
        check_val("valid_after", valid_out, 0);
        tick();
        check_val("done_once", done, 0);
        check_val("ready_back", ready, 1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check_val($sformatf("pe_%0d_%0d", i, j), 64'(acc[i][j]), 64'(prod(i, j)));
    endtask

    initial begin
        int c, p, ph;
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0; start = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin ref_a[i][j] = '0; ref_b[i][j] = '0; end
        #12;
        check_val("rst_ready", ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_west", west_data, 0);
        check_val("rst_north", north_data, 0);
        check_val("rst_flags", {valid_out, array_clr, done}, 0);
        rst = 1'b0;
        tick();

        // Identity A, counting B.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                write_el(1'b0, i, j, (i == j) ? 8'd1 : 8'd0);
                write_el(1'b1, i, j, 8'(i * 4 + j + 1));
            end
        run_feed(1'b0);
        for (int t = 0; t < 4; t++) begin
            check_val($sformatf("id_w0_t%0d", t), w_hist[t][0], (t == 0) ? 1 : 0);
            check_val($sformatf("id_n3_t%0d", t + 3), n_hist[t+3][3], 4 * (t + 1));
        end

        // All twos: every PE sums four 2*2 products.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                write_el(1'b0, i, j, 8'd2);
                write_el(1'b1, i, j, 8'd2);
            end
        run_feed(1'b0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check_val($sformatf("pe16_%0d_%0d", i, j), 64'(acc[i][j]), 16);

        // Random matrices; last round also writes coincident with start.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    write_el(1'b0, i, j, 8'($urandom));
                    write_el(1'b1, i, j, 8'($urandom));
                end
            if (r == 2) begin
                wr_en = 1'b1; wr_sel = 1'b1; wr_row = 2'd2; wr_col = 2'd1; wr_data = 8'($urandom);
                ref_b[2][1] = wr_data;
            end
            run_feed(1'b0);
        end

        // Write during FEED must be dropped; the next run still feeds the original A[0][0].
        run_feed(1'b1);
        run_feed(1'b0);

        // Reset in the middle of FEED.
        start = 1'b1;
        tick();
        start = 1'b0;
        clr_exp += CLR;
        c = 1;
        while (!valid_out && c < 4) begin tick(); c++; end
        check_val("rstmid_lat", c, CLR + 1);
        for (int t = 0; t < 5; t++) tick();
        #2;
        rst = 1'b1;
        #1;
        check_val("rstmid_west", west_data, 0);
        check_val("rstmid_north", north_data, 0);
        check_val("rstmid_flags", {valid_out, array_clr, done, busy}, 0);
        check_val("rstmid_ready", ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin ref_a[i][j] = '0; ref_b[i][j] = '0; end
        run_feed(1'b0);

        // Start held high: back-to-back runs with one done pulse each.
        p = CLR + FL + 2;
        start = 1'b1;
        for (c = 1; c <= 3 * p; c++) begin
            tick();
            ph = c % p;
            check_val($sformatf("b2b_done_c%0d", c), done, (ph == p - 1) ? 1 : 0);
            check_val($sformatf("b2b_valid_c%0d", c), valid_out,
                      (ph >= CLR + 1 && ph <= CLR + FL) ? 1 : 0);
        end
        start = 1'b0;
        clr_exp += 3 * CLR;
        tick();
        tick();

        check_val("clr_cycles", clr_seen, clr_exp);
        check_val("ready_busy_overlap", both_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
